// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and helpers for the multicycle core sequencer
package core_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    EXECUTE = 3'd3,
    MEM     = 3'd4,
    WRITE   = 3'd5,
    HALT    = 3'd7
  } seq_state_t;

  typedef enum logic [1:0] {
    TRAP_NONE     = 2'd0,
    TRAP_ILLEGAL  = 2'd1,
    TRAP_FETCH_TO = 2'd2,
    TRAP_MEM_TO   = 2'd3
  } trap_cause_t;

  // States that wait on a memory VALID and are therefore guarded by the timer
  function automatic logic is_wait_state(input seq_state_t s);
    return (s == FETCH) || (s == MEM);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - loadable up-counter flagging the last allowed wait cycle
module wait_timer #(
  parameter int LIMIT = 255,
  parameter int W     = $clog2(LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count;

  // Clear has priority over load, load over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  // LIMIT-1 idle cycles already counted: this cycle is the last one allowed
  assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - fetch/decode/execute/mem/write control FSM with trap and retire count
module core_sequencer
  import core_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int INSTRET_W = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RUN,
  output logic                 IMEM_REQ,
  input  logic                 IMEM_VALID,
  output logic                 INST_LATCH,
  output logic                 DEC_EN,
  input  logic                 ILLEGAL,
  input  logic                 IS_LOAD,
  input  logic                 IS_STORE,
  input  logic                 WB_EN,
  output logic                 EXE_START,
  input  logic                 EXE_DONE,
  output logic                 DMEM_REQ,
  output logic                 DMEM_WE,
  input  logic                 DMEM_VALID,
  output logic                 RF_WE,
  output logic                 PC_WE,
  output logic                 TRAP,
  output logic [1:0]           TRAP_CAUSE,
  output logic [2:0]           STATE,
  output logic [INSTRET_W-1:0] INSTRET
);

  localparam int TW = $clog2(TIMEOUT + 1);

  seq_state_t           state, state_n;
  trap_cause_t          cause_q, cause_n;
  logic                 first_q;
  logic                 is_load_q, is_store_q, wb_en_q;
  logic                 latch_flags;
  logic                 tmr_clr, tmr_en, tmr_expired;
  logic [INSTRET_W-1:0] instret_q;

  // The timer sits at zero outside FETCH/MEM, so it always starts clean on entry
  assign tmr_clr = !is_wait_state(state);
  assign tmr_en  = ((state == FETCH) && !IMEM_VALID) || ((state == MEM) && !DMEM_VALID);

  wait_timer #(
    .LIMIT (TIMEOUT),
    .W     (TW)
  ) u_wait_timer (
    .clk      (CLK),
    .rst      (RST),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .load     (1'b0),
    .load_val ('0),
    .expired  (tmr_expired)
  );

  // State register plus a marker that is high in the first cycle of each state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      first_q <= 1'b0;
    end else begin
      state   <= state_n;
      first_q <= (state_n != state);
    end
  end

  // Decoder flags, trap cause and retired-instruction counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      is_load_q  <= 1'b0;
      is_store_q <= 1'b0;
      wb_en_q    <= 1'b0;
      cause_q    <= TRAP_NONE;
      instret_q  <= '0;
    end else begin
      if (latch_flags) begin
        is_load_q  <= IS_LOAD;
        is_store_q <= IS_STORE;
        wb_en_q    <= WB_EN;
      end
      cause_q <= cause_n;
      if (state == WRITE) begin
        instret_q <= instret_q + INSTRET_W'(1);
      end
    end
  end

  // Next-state logic and Moore strobes decoded from state and latched flags only
  always_comb begin
    state_n     = state;
    cause_n     = cause_q;
    latch_flags = 1'b0;
    IMEM_REQ    = 1'b0;
    INST_LATCH  = 1'b0;
    DEC_EN      = 1'b0;
    EXE_START   = 1'b0;
    DMEM_REQ    = 1'b0;
    DMEM_WE     = 1'b0;
    RF_WE       = 1'b0;
    PC_WE       = 1'b0;
    TRAP        = 1'b0;
    case (state)
      IDLE: begin
        if (RUN) state_n = FETCH;
      end
      FETCH: begin
        IMEM_REQ = 1'b1;
        if (IMEM_VALID) begin
          state_n = DECODE;
        end else if (tmr_expired) begin
          state_n = HALT;
          cause_n = TRAP_FETCH_TO;
        end
      end
      DECODE: begin
        if (first_q) begin
          INST_LATCH = 1'b1;
        end else begin
          DEC_EN = 1'b1;
          if (ILLEGAL || (IS_LOAD && IS_STORE)) begin
            state_n = HALT;
            cause_n = TRAP_ILLEGAL;
          end else begin
            latch_flags = 1'b1;
            state_n     = EXECUTE;
          end
        end
      end
      EXECUTE: begin
        EXE_START = first_q;
        if (EXE_DONE) state_n = (is_load_q || is_store_q) ? MEM : WRITE;
      end
      MEM: begin
        DMEM_REQ = 1'b1;
        DMEM_WE  = is_store_q;
        if (DMEM_VALID) begin
          state_n = WRITE;
        end else if (tmr_expired) begin
          state_n = HALT;
          cause_n = TRAP_MEM_TO;
        end
      end
      WRITE: begin
        PC_WE   = 1'b1;
        RF_WE   = wb_en_q && !is_store_q;
        state_n = RUN ? FETCH : IDLE;
      end
      HALT: begin
        TRAP = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign TRAP_CAUSE = cause_q;
  assign STATE      = state;
  assign INSTRET    = instret_q;

endmodule
